axi2mem_drain_ctrl: RTL and testbench

Controller that schedules AXI-to-memory bridge traffic around outstanding-transaction tracking. Per channel it counts AW/B and AR/R handshakes, throttles new address acceptance at a programmable outstanding limit, and sequences a drain/quiesce handshake for power, clock-gating or reconfiguration logic. It sits beside the bridge's AW/AR address stages and gates their ready/valid acceptance via `aw_allow_o`/`ar_allow_o`.

---
 rtl/axi2mem_drain_pkg.sv | 11 +
 rtl/axi2mem_outstanding_cnt.sv | 47 ++++
 rtl/axi2mem_drain_ctrl.sv | 139 +++++++++++++
 tb/tb_axi2mem_drain_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/axi2mem_drain_pkg.sv
// Shared types for the AXI-to-memory drain controller.
// Holds the drain FSM state encoding used by the top level.
package axi2mem_drain_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        QUIESCED = 2'd2
    } drain_state_e;

endpackage

// File: rtl/axi2mem_outstanding_cnt.sv
// Saturating outstanding-transaction counter for one AXI channel pair.
// Reports single-cycle pulses when a decrement hits zero or an increment hits full scale.
module axi2mem_outstanding_cnt #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 underflow_o,
    output logic                 overflow_o
);

    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    // Simultaneous inc and dec cancel, so only the one-sided cases move the count.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = 1'b0;
        overflow_o  = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == {CNT_WIDTH{1'b1}}) begin
                overflow_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/axi2mem_drain_ctrl.sv
// Outstanding-transaction throttle and drain/quiesce sequencer for an AXI-to-memory bridge.
// Every output is taken from flops so the bridge sees no combinational input-to-output path.
module axi2mem_drain_ctrl
    import axi2mem_drain_pkg::*;
#(
    parameter int CNT_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int DRAIN_TIMEOUT   = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_sync_i,
    input  logic                 b_sync_i,
    input  logic                 ar_sync_i,
    input  logic                 r_sync_i,
    input  logic                 drain_req_i,
    input  logic                 err_clr_i,
    output logic                 aw_allow_o,
    output logic                 ar_allow_o,
    output logic                 drain_ack_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] aw_cnt_o,
    output logic [CNT_WIDTH-1:0] ar_cnt_o,
    output logic                 underflow_o,
    output logic                 overrun_o,
    output logic                 timeout_o
);

    localparam int TMR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(DRAIN_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(MAX_OUTSTANDING);

    drain_state_e     state_d, state_q;
    logic [TMR_W-1:0] tmr_d, tmr_q;
    logic             underflow_d, underflow_q;
    logic             overrun_d, overrun_q;
    logic             timeout_d, timeout_q;

    logic [CNT_WIDTH-1:0] aw_cnt, ar_cnt;
    logic                 aw_underflow, aw_overflow;
    logic                 ar_underflow, ar_overflow;
    logic                 aw_allow, ar_allow;
    logic                 timeout_evt;

    axi2mem_outstanding_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_aw_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (aw_sync_i),
        .dec_i       (b_sync_i),
        .cnt_o       (aw_cnt),
        .underflow_o (aw_underflow),
        .overflow_o  (aw_overflow)
    );

    axi2mem_outstanding_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ar_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (ar_sync_i),
        .dec_i       (r_sync_i),
        .cnt_o       (ar_cnt),
        .underflow_o (ar_underflow),
        .overflow_o  (ar_overflow)
    );

    // Allows come from registered state and counts only, so a B at the limit cannot reopen AW this cycle.
    assign aw_allow = (state_q == RUN) && (aw_cnt < CNT_LIMIT);
    assign ar_allow = (state_q == RUN) && (ar_cnt < CNT_LIMIT);

    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        unique case (state_q)
            RUN: begin
                if (drain_req_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                tmr_d = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
                if (!drain_req_i) begin
                    state_d = RUN;
                end else if (aw_cnt == '0 && ar_cnt == '0) begin
                    state_d = QUIESCED;
                end
            end
            QUIESCED: begin
                if (!drain_req_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // The timer holds the number of completed DRAIN cycles; this flags the cycle that completes the budget.
    assign timeout_evt = (DRAIN_TIMEOUT != 0) && (state_q == DRAIN) && (tmr_q >= TMR_LAST);

    always_comb begin
        underflow_d = aw_underflow || ar_underflow || (underflow_q && !err_clr_i);
        overrun_d   = aw_overflow || ar_overflow
                      || (aw_sync_i && !aw_allow) || (ar_sync_i && !ar_allow)
                      || (overrun_q && !err_clr_i);
        timeout_d   = timeout_evt || (timeout_q && !err_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            tmr_q       <= '0;
            underflow_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            underflow_q <= underflow_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign aw_allow_o  = aw_allow;
    assign ar_allow_o  = ar_allow;
    assign drain_ack_o = (state_q == QUIESCED);
    assign busy_o      = (aw_cnt != '0) || (ar_cnt != '0);
    assign aw_cnt_o    = aw_cnt;
    assign ar_cnt_o    = ar_cnt;
    assign underflow_o = underflow_q;
    assign overrun_o   = overrun_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_axi2mem_drain_ctrl.sv
// Directed self-checking bench for axi2mem_drain_ctrl with hand-computed expectations.
module tb_axi2mem_drain_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       aw_sync_i, b_sync_i, ar_sync_i, r_sync_i;
    logic       drain_req_i, err_clr_i;
    logic       aw_allow_o, ar_allow_o, drain_ack_o, busy_o;
    logic [3:0] aw_cnt_o, ar_cnt_o;
    logic       underflow_o, overrun_o, timeout_o;

    int errors = 0;
    int checks = 0;

    axi2mem_drain_ctrl #(
        .CNT_WIDTH       (4),
        .MAX_OUTSTANDING (8),
        .DRAIN_TIMEOUT   (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .aw_sync_i   (aw_sync_i),
        .b_sync_i    (b_sync_i),
        .ar_sync_i   (ar_sync_i),
        .r_sync_i    (r_sync_i),
        .drain_req_i (drain_req_i),
        .err_clr_i   (err_clr_i),
        .aw_allow_o  (aw_allow_o),
        .ar_allow_o  (ar_allow_o),
        .drain_ack_o (drain_ack_o),
        .busy_o      (busy_o),
        .aw_cnt_o    (aw_cnt_o),
        .ar_cnt_o    (ar_cnt_o),
        .underflow_o (underflow_o),
        .overrun_o   (overrun_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic aw, input logic b, input logic ar,
                                 input logic r, input logic clr);
        aw_sync_i = aw;
        b_sync_i  = b;
        ar_sync_i = ar;
        r_sync_i  = r;
        err_clr_i = clr;
        tick();
        aw_sync_i = 1'b0;
        b_sync_i  = 1'b0;
        ar_sync_i = 1'b0;
        r_sync_i  = 1'b0;
        err_clr_i = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        aw_sync_i   = 1'b0;
        b_sync_i    = 1'b0;
        ar_sync_i   = 1'b0;
        r_sync_i    = 1'b0;
        drain_req_i = 1'b0;
        err_clr_i   = 1'b0;
        rst_ni      = 1'b0;
        #3;
        checkOutput("rst_aw_cnt", 32'(aw_cnt_o), 0);
        checkOutput("rst_ar_cnt", 32'(ar_cnt_o), 0);
        checkOutput("rst_aw_allow", 32'(aw_allow_o), 1);
        checkOutput("rst_ar_allow", 32'(ar_allow_o), 1);
        checkOutput("rst_busy", 32'(busy_o), 0);
        checkOutput("rst_ack", 32'(drain_ack_o), 0);
        checkOutput("rst_flags", {29'd0, underflow_o, overrun_o, timeout_o}, 0);
        #9 rst_ni = 1'b1;
        tick();

        // Fill AW to the outstanding limit
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("lim_aw_cnt", 32'(aw_cnt_o), 8);
        checkOutput("lim_aw_allow", 32'(aw_allow_o), 0);
        checkOutput("lim_ar_allow", 32'(ar_allow_o), 1);
        checkOutput("lim_busy", 32'(busy_o), 1);
        checkOutput("lim_no_overrun", 32'(overrun_o), 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("lim_b_cnt", 32'(aw_cnt_o), 7);
        checkOutput("lim_b_allow", 32'(aw_allow_o), 1);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("ovr_cnt", 32'(aw_cnt_o), 9);
        checkOutput("ovr_flag", 32'(overrun_o), 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("ovr_clr", 32'(overrun_o), 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("empty_cnt", 32'(aw_cnt_o), 0);
        checkOutput("empty_busy", 32'(busy_o), 0);
        checkOutput("empty_no_uf", 32'(underflow_o), 0);

        // Simultaneous inc and dec hold the count
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("both_hold", 32'(aw_cnt_o), 5);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("both_drained", 32'(aw_cnt_o), 0);

        // Drain with 3 AW and 2 AR outstanding
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("dr_ar_cnt", 32'(ar_cnt_o), 2);
        drain_req_i = 1'b1;
        tick();
        checkOutput("dr_aw_allow", 32'(aw_allow_o), 0);
        checkOutput("dr_ar_allow", 32'(ar_allow_o), 0);
        checkOutput("dr_ack0", 32'(drain_ack_o), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("dr_aw_zero", 32'(aw_cnt_o), 0);
        checkOutput("dr_ack_pend_r", 32'(drain_ack_o), 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("dr_ar_zero", 32'(ar_cnt_o), 0);
        checkOutput("dr_ack_same", 32'(drain_ack_o), 0);
        tick();
        checkOutput("dr_ack1", 32'(drain_ack_o), 1);
        checkOutput("dr_no_timeout", 32'(timeout_o), 0);
        drain_req_i = 1'b0;
        tick();
        checkOutput("rel_ack", 32'(drain_ack_o), 0);
        checkOutput("rel_allow", 32'(aw_allow_o), 1);

        // Drain with nothing outstanding, then illegal AW while quiesced
        drain_req_i = 1'b1;
        tick();
        checkOutput("fast_ack_c1", 32'(drain_ack_o), 0);
        tick();
        checkOutput("fast_ack_c2", 32'(drain_ack_o), 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("q_overrun", 32'(overrun_o), 1);
        checkOutput("q_aw_cnt", 32'(aw_cnt_o), 1);
        drain_req_i = 1'b0;
        tick();
        checkOutput("q_rel_ack", 32'(drain_ack_o), 0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("q_clr_overrun", 32'(overrun_o), 0);
        checkOutput("q_cnt_back", 32'(aw_cnt_o), 0);

        // Underflow, and error event winning over a same-cycle clear
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("uf_flag", 32'(underflow_o), 1);
        checkOutput("uf_cnt", 32'(aw_cnt_o), 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("uf_clr", 32'(underflow_o), 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("uf_wins_clr", 32'(underflow_o), 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("uf_clr2", 32'(underflow_o), 0);

        // Drain timeout with one AW that never completes
        applyStimulus(1, 0, 0, 0, 0);
        drain_req_i = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        checkOutput("to_before", 32'(timeout_o), 0);
        tick();
        checkOutput("to_set", 32'(timeout_o), 1);
        checkOutput("to_no_ack", 32'(drain_ack_o), 0);
        drain_req_i = 1'b0;
        tick();
        checkOutput("to_rel_allow", 32'(aw_allow_o), 1);
        checkOutput("to_sticky", 32'(timeout_o), 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("to_clr", 32'(timeout_o), 0);

        // Reset in the middle of a drain
        applyStimulus(1, 0, 1, 0, 0);
        drain_req_i = 1'b1;
        tick();
        rst_ni = 1'b0;
        #1;
        checkOutput("mid_rst_cnt", 32'({aw_cnt_o, ar_cnt_o}), 0);
        checkOutput("mid_rst_allow", 32'(aw_allow_o), 1);
        drain_req_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
